avalon_hex_display_ctrl: RTL and testbench

//  Avalon-MM slave driving NUM_DIGITS active-low 7-segment digits on the HPS lightweight bridge.

---
 rtl/hex_disp_pkg.sv | 33 +++
 rtl/hex7seg_decode.sv | 11 +
 rtl/avalon_hex_display_ctrl.sv | 159 +++++++++++++++
 tb/tb_avalon_hex_display_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants for the Avalon hex display controller: register map,
// CTRL bit positions, segment glyphs and the blink phase encoding.
package hex_disp_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_BLANK  = 3'd2;
  localparam logic [2:0] REG_BLINK  = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_BLINK_EN   = 1;
  localparam int CTRL_SCROLL_EN  = 2;
  localparam int CTRL_SCROLL_DIR = 3;

  localparam logic [6:0] SEG_DARK = 7'h7F;

  // Active-low gfedcba glyphs, nibble 0 in the low seven bits.
  localparam logic [111:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    BLINK_HIDDEN  = 1'b0,
    BLINK_VISIBLE = 1'b1
  } blink_state_e;

  function automatic logic [6:0] glyph_of(input logic [3:0] nib);
    return GLYPH_TABLE[7*nib +: 7];
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex7seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = glyph_of(i_nibble);

endmodule

// File: rtl/avalon_hex_display_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS active-low seven-segment digits with
// per-digit blank/blink masks, timed nibble scrolling and a STATUS readback.
module avalon_hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HZ   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic [7*NUM_DIGITS-1:0] hex_export
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [DW-1:0]            r_data;
  logic [3:0]               r_ctrl;
  logic [NUM_DIGITS-1:0]    r_blank;
  logic [NUM_DIGITS-1:0]    r_blink;
  logic [7:0]               r_step_cnt;
  logic [CW-1:0]            r_tick_cnt;
  logic [31:0]              r_readdata;
  logic [7*NUM_DIGITS-1:0]  r_hex;
  blink_state_e             r_blink_state;
  blink_state_e             w_blink_next;

  logic                     w_tick;
  logic                     w_blink_phase;
  logic                     w_wr_data, w_wr_ctrl, w_wr_blank, w_wr_blink;
  logic                     w_scroll_step;
  logic [DW-1:0]            w_rot_left, w_rot_right;
  logic [7*NUM_DIGITS-1:0]  w_glyph;
  logic [7*NUM_DIGITS-1:0]  w_hex_next;
  logic [NUM_DIGITS-1:0]    w_dark;
  logic                     w_unused;

  assign w_unused   = ^avs_writedata;
  assign w_wr_data  = avs_write && (avs_address == REG_DATA);
  assign w_wr_ctrl  = avs_write && (avs_address == REG_CTRL);
  assign w_wr_blank = avs_write && (avs_address == REG_BLANK);
  assign w_wr_blink = avs_write && (avs_address == REG_BLINK);

  // Free-running timebase, independent of EN.
  assign w_tick = (r_tick_cnt == CW'(HALF - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Blink FSM: state register, next-state logic, output decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_state <= BLINK_VISIBLE;
    end else begin
      r_blink_state <= w_blink_next;
    end
  end

  always_comb begin
    w_blink_next = r_blink_state;
    if (w_wr_ctrl && !avs_writedata[CTRL_BLINK_EN]) begin
      w_blink_next = BLINK_VISIBLE;
    end else if (!r_ctrl[CTRL_BLINK_EN]) begin
      w_blink_next = BLINK_VISIBLE;
    end else if (w_tick) begin
      w_blink_next = (r_blink_state == BLINK_VISIBLE) ? BLINK_HIDDEN : BLINK_VISIBLE;
    end
  end

  always_comb begin
    w_blink_phase = (r_blink_state == BLINK_VISIBLE);
  end

  // Modulo indexing keeps the rotator valid for a single digit as well.
  always_comb begin
    w_rot_left  = '0;
    w_rot_right = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      w_rot_left[4*((d+1) % NUM_DIGITS) +: 4] = r_data[4*d +: 4];
      w_rot_right[4*d +: 4] = r_data[4*((d+1) % NUM_DIGITS) +: 4];
    end
  end

  assign w_scroll_step = w_tick && r_ctrl[CTRL_SCROLL_EN] && !w_wr_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= '0;
      r_ctrl     <= '0;
      r_blank    <= '0;
      r_blink    <= '0;
      r_step_cnt <= '0;
    end else begin
      if (w_wr_data) begin
        r_data <= avs_writedata[DW-1:0];
      end else if (w_scroll_step) begin
        r_data <= r_ctrl[CTRL_SCROLL_DIR] ? w_rot_right : w_rot_left;
      end
      if (w_scroll_step) r_step_cnt <= r_step_cnt + 8'd1;
      if (w_wr_ctrl)  r_ctrl  <= avs_writedata[3:0];
      if (w_wr_blank) r_blank <= avs_writedata[NUM_DIGITS-1:0];
      if (w_wr_blink) r_blink <= avs_writedata[NUM_DIGITS-1:0];
    end
  end

  // Read data reflects pre-edge state, so a same-edge write returns the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        REG_DATA:   r_readdata <= 32'(r_data);
        REG_CTRL:   r_readdata <= 32'(r_ctrl);
        REG_BLANK:  r_readdata <= 32'(r_blank);
        REG_BLINK:  r_readdata <= 32'(r_blink);
        REG_STATUS: r_readdata <= {16'h0000, r_step_cnt, 7'h00, w_blink_phase};
        default:    r_readdata <= '0;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      hex7seg_decode u_dec (
        .i_nibble (r_data[4*gi +: 4]),
        .o_seg    (w_glyph[7*gi +: 7])
      );
      assign w_dark[gi] = !r_ctrl[CTRL_EN] || r_blank[gi] ||
                          (r_blink[gi] && !w_blink_phase);
      assign w_hex_next[7*gi +: 7] = w_dark[gi] ? SEG_DARK : w_glyph[7*gi +: 7];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hex <= '1;
    end else begin
      r_hex <= w_hex_next;
    end
  end

  assign avs_readdata = r_readdata;
  assign hex_export   = r_hex;

endmodule

// File: tb/tb_avalon_hex_display_ctrl.sv
// Directed bench for avalon_hex_display_ctrl with a 4-cycle half-period timebase.
module tb_avalon_hex_display_ctrl;

  localparam int ND = 6;
  localparam int KWR = 0;
  localparam int KRD = 1;
  localparam int KHX = 2;
  localparam logic [41:0] ALL_DARK = 42'h3FF_FFFF_FFFF;

  logic        clk;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [41:0] hex_export;

  int checks;
  int errors;
  int tb_cnt;

  typedef struct {
    int          kind;
    logic [2:0]  addr;
    logic [31:0] val;
    logic [41:0] hex;
  } vec_t;

  vec_t vecs[29];

  avalon_hex_display_ctrl #(
    .NUM_DIGITS (ND),
    .CLK_HZ     (8),
    .BLINK_HZ   (1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .hex_export    (hex_export)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model of the timebase: value 3 before an edge means that edge ticks.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cnt <= 0;
    else          tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
  end

  function automatic logic [41:0] hx(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_wr(input logic [2:0] addr, input logic [31:0] data);
    avs_address = addr; avs_writedata = data; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic do_rd(input string name, input logic [2:0] addr, input logic [31:0] exp);
    avs_address = addr; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    check(name, 64'(avs_readdata), 64'(exp));
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_cnt != 0 && n < 8);
    if (tb_cnt != 0) begin
      errors++;
      $display("FAIL wait_tick: timebase never wrapped");
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;

    vecs[0]  = '{KRD, 3'd4, 32'h1, '0};
    vecs[1]  = '{KWR, 3'd1, 32'h1, '0};
    vecs[2]  = '{KWR, 3'd0, 32'hA5, '0};
    vecs[3]  = '{KHX, 3'd0, 32'h0, hx(7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12)};
    vecs[4]  = '{KRD, 3'd1, 32'h1, '0};
    vecs[5]  = '{KWR, 3'd2, 32'h3F, '0};
    vecs[6]  = '{KHX, 3'd0, 32'h0, ALL_DARK};
    vecs[7]  = '{KRD, 3'd2, 32'h3F, '0};
    vecs[8]  = '{KWR, 3'd2, 32'hFF0, '0};
    vecs[9]  = '{KRD, 3'd2, 32'h30, '0};
    vecs[10] = '{KHX, 3'd0, 32'h0, hx(7'h7F, 7'h7F, 7'h40, 7'h40, 7'h08, 7'h12)};
    vecs[11] = '{KWR, 3'd0, 32'hFFFF_FFFF, '0};
    vecs[12] = '{KRD, 3'd0, 32'h00FF_FFFF, '0};
    vecs[13] = '{KHX, 3'd0, 32'h0, hx(7'h7F, 7'h7F, 7'h0E, 7'h0E, 7'h0E, 7'h0E)};
    vecs[14] = '{KWR, 3'd6, 32'hDEAD_BEEF, '0};
    vecs[15] = '{KRD, 3'd6, 32'h0, '0};
    vecs[16] = '{KRD, 3'd5, 32'h0, '0};
    vecs[17] = '{KWR, 3'd1, 32'h0, '0};
    vecs[18] = '{KWR, 3'd2, 32'h0, '0};
    vecs[19] = '{KHX, 3'd0, 32'h0, ALL_DARK};
    vecs[20] = '{KWR, 3'd3, 32'hFFFF, '0};
    vecs[21] = '{KRD, 3'd3, 32'h3F, '0};
    vecs[22] = '{KWR, 3'd1, 32'h1, '0};
    vecs[23] = '{KHX, 3'd0, 32'h0, hx(7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E)};
    vecs[24] = '{KRD, 3'd4, 32'h1, '0};
    vecs[25] = '{KWR, 3'd0, 32'h9B7C3D, '0};
    vecs[26] = '{KHX, 3'd0, 32'h0, hx(7'h10, 7'h03, 7'h78, 7'h46, 7'h30, 7'h21)};
    vecs[27] = '{KWR, 3'd0, 32'h2468E1, '0};
    vecs[28] = '{KHX, 3'd0, 32'h0, hx(7'h24, 7'h19, 7'h02, 7'h00, 7'h06, 7'h79)};

    repeat (2) @(negedge clk);
    check("reset_hex", 64'(hex_export), 64'(ALL_DARK));
    check("reset_rdata", 64'(avs_readdata), 64'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      case (vecs[i].kind)
        KWR: do_wr(vecs[i].addr, vecs[i].val);
        KRD: do_rd($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].val);
        default: begin
          @(negedge clk);
          check($sformatf("vec%0d_hex", i), 64'(hex_export), 64'(vecs[i].hex));
        end
      endcase
    end

    // Simultaneous read and write of DATA returns the old value, then holds.
    avs_address = 3'd0; avs_writedata = 32'h111111; avs_write = 1'b1; avs_read = 1'b1;
    @(negedge clk);
    avs_write = 1'b0; avs_read = 1'b0;
    check("rw_same_old", 64'(avs_readdata), 64'h2468E1);
    repeat (3) @(negedge clk);
    check("rdata_hold", 64'(avs_readdata), 64'h2468E1);
    do_rd("rw_same_new", 3'd0, 32'h111111);

    // Blink digit0 only.
    do_wr(3'd0, 32'hA5);
    do_wr(3'd3, 32'h01);
    do_wr(3'd1, 32'h3);
    wait_tick();
    @(negedge clk);
    check("blink_dark_a", 64'(hex_export), 64'(hx(7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h7F)));
    repeat (3) @(negedge clk);
    check("blink_dark_b", 64'(hex_export), 64'(hx(7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h7F)));
    @(negedge clk);
    check("blink_lit_a", 64'(hex_export), 64'(hx(7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12)));
    repeat (3) @(negedge clk);
    check("blink_lit_b", 64'(hex_export), 64'(hx(7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12)));
    @(negedge clk);
    check("blink_dark_c", 64'(hex_export), 64'(hx(7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h7F)));
    do_wr(3'd1, 32'h1);
    check("blink_clr_pre", 64'(hex_export), 64'(hx(7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h7F)));
    @(negedge clk);
    check("blink_clr_lit", 64'(hex_export), 64'(hx(7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12)));
    do_rd("blink_clr_status", 3'd4, 32'h1);

    // Scroll left six steps, then one right.
    do_wr(3'd0, 32'h012345);
    do_wr(3'd1, 32'h5);
    wait_tick();
    do_rd("scroll_l1", 3'd0, 32'h123450);
    check("scroll_l1_hex", 64'(hex_export), 64'(hx(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h40)));
    repeat (5) wait_tick();
    do_rd("scroll_l6", 3'd0, 32'h012345);
    do_rd("scroll_cnt6", 3'd4, 32'h601);
    do_wr(3'd1, 32'hD);
    wait_tick();
    do_rd("scroll_r1", 3'd0, 32'h501234);
    do_rd("scroll_cnt7", 3'd4, 32'h701);

    // CPU DATA write on the tick edge beats the scroll step.
    begin
      int n = 0;
      while (tb_cnt != 3 && n < 8) begin
        @(negedge clk);
        n++;
      end
    end
    do_wr(3'd0, 32'hABCDEF);
    do_rd("collide_data", 3'd0, 32'hABCDEF);
    do_rd("collide_cnt", 3'd4, 32'h701);
    do_wr(3'd1, 32'h1);
    check("collide_hex", 64'(hex_export), 64'(hx(7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E)));

    // Reset in the middle of a DATA write.
    avs_address = 3'd0; avs_writedata = 32'h777777; avs_write = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_hex", 64'(hex_export), 64'(ALL_DARK));
    check("midrst_rdata", 64'(avs_readdata), 64'h0);
    @(negedge clk);
    avs_write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    do_rd("midrst_status", 3'd4, 32'h1);
    do_rd("midrst_data", 3'd0, 32'h0);
    do_rd("midrst_ctrl", 3'd1, 32'h0);
    check("midrst_hex2", 64'(hex_export), 64'(ALL_DARK));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
